// File: rtl/ipg_resp_gen_pkg.sv
// ipg_resp_gen_pkg: IPG side-channel opcodes, request field positions and responder states,
// shared with the request generator.
package ipg_resp_gen_pkg;
    localparam logic [7:0] IPG_OP_READ  = 8'h01;
    localparam logic [7:0] IPG_OP_RRESP = 8'h02;
    localparam int IPG_OP_LSB   = 56;
    localparam int IPG_TAG_LSB  = 48;
    localparam int IPG_LEN_LSB  = 40;
    localparam int IPG_ADDR_LSB = 0;
    typedef enum logic [1:0] {IDLE, HDR, RD, BEAT} ipg_state_t;
endpackage

// File: rtl/ipg_req_queue.sv
// ipg_req_queue: synchronous FIFO of pending read requests, pointer-based with a wrap bit.
module ipg_req_queue #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign dout  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/ipg_resp_gen.sv
// ipg_resp_gen: answers queued IPG READ requests with a header chunk followed by
// `length` memory words, one chunk per transmit handshake.
module ipg_resp_gen
    import ipg_resp_gen_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 10,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] req_chunk,
    input  logic                  req_valid,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] resp_chunk,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  req_drop,
    output logic [15:0]           drop_count,
    output logic                  busy
);
    logic [47:0] q_din, q_dout;
    logic q_push, q_pop, q_full, q_empty, rd_req, fresh, unused_bits;
    logic [7:0] rem;
    logic [DATA_WIDTH-1:0] out_q;
    ipg_state_t state;

    assign rd_req      = req_valid && req_chunk[IPG_OP_LSB +: 8] == IPG_OP_READ;
    assign q_push      = rd_req && !q_full;
    assign q_pop       = state == IDLE && !q_empty;
    assign q_din       = {req_chunk[IPG_TAG_LSB +: 8], req_chunk[IPG_LEN_LSB +: 8], req_chunk[IPG_ADDR_LSB +: 32]};
    assign busy        = state != IDLE || !q_empty;
    assign unused_bits = ^{req_chunk[39:32], q_dout[31:ADDR_WIDTH]};
    // Memory data arrives in the first BEAT cycle; it is forwarded then and held in out_q on stalls.
    assign resp_chunk  = (state == BEAT && fresh) ? mem_rd_data : out_q;

    ipg_req_queue #(.WIDTH(48), .DEPTH(QUEUE_DEPTH)) u_queue (
        .clk(clk), .rst(rst), .push(q_push), .din(q_din),
        .pop(q_pop), .dout(q_dout), .full(q_full), .empty(q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            out_q      <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            req_drop   <= 1'b0;
            drop_count <= '0;
            rem        <= '0;
            fresh      <= 1'b0;
        end else begin
            req_drop  <= rd_req && q_full;
            if (rd_req && q_full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            mem_rd_en <= 1'b0;
            fresh     <= 1'b0;
            case (state)
                IDLE: if (!q_empty) begin
                    out_q      <= {IPG_OP_RRESP, q_dout[47:32], 40'd0};
                    rem        <= q_dout[39:32];
                    mem_addr   <= q_dout[ADDR_WIDTH-1:0];
                    resp_valid <= 1'b1;
                    state      <= HDR;
                end
                HDR: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    mem_rd_en  <= rem != 8'd0;
                    state      <= rem != 8'd0 ? RD : IDLE;
                end
                RD: begin
                    resp_valid <= 1'b1;
                    fresh      <= 1'b1;
                    state      <= BEAT;
                end
                BEAT: begin
                    if (fresh) out_q <= mem_rd_data;
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rem        <= rem - 8'd1;
                        mem_addr   <= mem_addr + 1'b1;
                        mem_rd_en  <= rem != 8'd1;
                        state      <= rem != 8'd1 ? RD : IDLE;
                    end
                end
            endcase
        end
    end
endmodule
